// File: rtl/cardio_mlp_pkg.sv
// Shared constants for the cardiotocography MLP classifier.
// Holds the default dimensions, the hard-wired signed weights and biases
// for both layers, and the class codes reported on the classifier output.
package cardio_mlp_pkg;

  localparam int unsigned WIDTH_A  = 4;
  localparam int unsigned NUM_A    = 21;
  localparam int unsigned OUTWIDTH = 2;
  localparam int unsigned NUM_H    = 5;
  localparam int unsigned NUM_C    = 3;
  localparam int unsigned WW       = 8;
  localparam int unsigned HSHIFT   = 4;
  localparam int unsigned ACTW     = 8;
  localparam int unsigned OSW      = 20;

  // Hidden accumulator wide enough that the full dot product never overflows.
  localparam int unsigned ACC1W = WW + WIDTH_A + 1 + $clog2(NUM_A + 1);

  typedef logic signed [WW-1:0] weight_t;

  typedef enum logic [OUTWIDTH-1:0] {
    CLS_NORMAL  = 2'd0,
    CLS_SUSPECT = 2'd1,
    CLS_PATHO   = 2'd2
  } cls_e;

  localparam weight_t W1 [NUM_H][NUM_A] = '{
    '{ 8'sd4, -8'sd2,  8'sd3,  8'sd0,  8'sd1, -8'sd1,  8'sd2,  8'sd5, -8'sd3,  8'sd0,  8'sd2,
       8'sd1, -8'sd2,  8'sd3,  8'sd0, -8'sd1,  8'sd4,  8'sd2, -8'sd2,  8'sd1,  8'sd0 },
    '{-8'sd3,  8'sd5,  8'sd0,  8'sd2, -8'sd4,  8'sd3,  8'sd1, -8'sd2,  8'sd6,  8'sd1, -8'sd1,
       8'sd0,  8'sd3, -8'sd2,  8'sd2,  8'sd4, -8'sd3,  8'sd1,  8'sd0,  8'sd2, -8'sd1 },
    '{ 8'sd2,  8'sd2, -8'sd5,  8'sd1,  8'sd3,  8'sd0, -8'sd2,  8'sd1,  8'sd2, -8'sd4,  8'sd3,
       8'sd2,  8'sd1,  8'sd0, -8'sd3,  8'sd2,  8'sd1, -8'sd1,  8'sd4,  8'sd0,  8'sd2 },
    '{-8'sd1,  8'sd0,  8'sd4, -8'sd3,  8'sd2,  8'sd5, -8'sd1,  8'sd0, -8'sd2,  8'sd3,  8'sd1,
      -8'sd4,  8'sd2,  8'sd1,  8'sd3, -8'sd2,  8'sd0,  8'sd4,  8'sd1, -8'sd3,  8'sd2 },
    '{-8'sd4, -8'sd3, -8'sd2, -8'sd5, -8'sd1, -8'sd2, -8'sd3, -8'sd1, -8'sd4, -8'sd2, -8'sd3,
      -8'sd1, -8'sd2, -8'sd4, -8'sd1, -8'sd3, -8'sd2, -8'sd1, -8'sd5, -8'sd2, -8'sd3 }
  };

  localparam weight_t B1 [NUM_H] = '{8'sd16, -8'sd32, 8'sd48, 8'sd0, 8'sd100};

  localparam weight_t W2 [NUM_C][NUM_H] = '{
    '{ 8'sd3, -8'sd2,  8'sd1,  8'sd0,  8'sd4},
    '{-8'sd1,  8'sd3,  8'sd0,  8'sd4, -8'sd2},
    '{ 8'sd1,  8'sd0, -8'sd2,  8'sd1,  8'sd5}
  };

  localparam weight_t B2 [NUM_C] = '{8'sd5, -8'sd10, 8'sd20};

endpackage

// File: rtl/cardio_mlp_classifier_if.sv
// Sample/result bus of the MLP classifier.
//   inp       packed unsigned features, feature i at [i*WIDTH_A +: WIDTH_A]
//   in_valid  inp valid this cycle
//   predo     raw signed class scores, class c at [c*OSW +: OSW]
//   out       predicted class index
//   out_valid out/predo valid
// master = sample source, slave = classifier.
interface cardio_mlp_classifier_if;
  import cardio_mlp_pkg::*;

  logic [NUM_A*WIDTH_A-1:0] inp;
  logic                     in_valid;
  logic [NUM_C*OSW-1:0]     predo;
  logic [OUTWIDTH-1:0]      out;
  logic                     out_valid;

  modport master (output inp, in_valid, input predo, out, out_valid);
  modport slave  (input inp, in_valid, output predo, out, out_valid);
endinterface

// File: rtl/mlp_neuron.sv
// Combinational neuron: bias + dot product of unsigned inputs with signed
// weights. With RELU_EN the result is clamped at zero, logically shifted
// right by SHIFT and narrowed to OUT_W bits (saturating when ACT_SAT_EN is
// defined, wrapping otherwise); without it the signed sum is passed on.
//   i_x    N_IN unsigned inputs, input i at [i*IN_W +: IN_W]
//   i_w    N_IN signed weights,  weight i at [i*W_W +: W_W]
//   i_b    signed bias
//   o_y_c  neuron output (combinational)
// Macro: ACT_SAT_EN
module mlp_neuron #(
  parameter int unsigned N_IN    = 21,
  parameter int unsigned IN_W    = 4,
  parameter int unsigned W_W     = 8,
  parameter int unsigned ACC_W   = 18,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned SHIFT   = 4,
  parameter bit          RELU_EN = 1'b1
) (
  input  logic [N_IN*IN_W-1:0]  i_x,
  input  logic [N_IN*W_W-1:0]   i_w,
  input  logic signed [W_W-1:0] i_b,
  output logic [OUT_W-1:0]      o_y_c
);

  localparam int unsigned PW = IN_W + W_W + 1;

  logic signed [ACC_W-1:0] w_acc;

  // Inputs are zero-extended by one bit so the product is a signed multiply.
  always_comb begin
    w_acc = ACC_W'(i_b);
    for (int i = 0; i < int'(N_IN); i++) begin
      w_acc = w_acc + ACC_W'(PW'(signed'({1'b0, i_x[i*IN_W +: IN_W]})) *
                             PW'(signed'(i_w[i*W_W +: W_W])));
    end
  end

  if (RELU_EN) begin : g_relu
`ifdef ACT_SAT_EN
    localparam logic [ACC_W-1:0] ACT_MAX = ACC_W'((64'd1 << OUT_W) - 64'd1);
    logic [ACC_W-1:0] w_sh;

    always_comb begin
      w_sh  = unsigned'(w_acc) >> SHIFT;
      o_y_c = '0;
      if (!w_acc[ACC_W-1]) begin
        o_y_c = (w_sh > ACT_MAX) ? '1 : OUT_W'(w_sh);
      end
    end
`else
    always_comb begin
      o_y_c = '0;
      if (!w_acc[ACC_W-1]) begin
        o_y_c = OUT_W'(unsigned'(w_acc) >> SHIFT);
      end
    end
`endif
  end else begin : g_lin
    always_comb begin
      o_y_c = OUT_W'(w_acc >>> SHIFT);
    end
  end

endmodule

// File: rtl/cardio_mlp_classifier.sv
// Fixed-weight two-layer MLP classifier for cardiotocography features.
// Stage 1 registers the ReLU hidden activations, stage 2 registers the
// class scores and their argmax (ties resolve to the lowest class index).
//   clk     clock, rising edge
//   rst     asynchronous active-high reset
//   io_bus  slave side of cardio_mlp_classifier_if (inp/in_valid in,
//           predo/out/out_valid out)
// Macro: ACT_SAT_EN (saturate hidden activations instead of wrapping)
module cardio_mlp_classifier
  import cardio_mlp_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  cardio_mlp_classifier_if.slave  io_bus
);

  logic [NUM_H*ACTW-1:0] w_act;
  logic [NUM_H*ACTW-1:0] r_act;
  logic                  r_v1;
  logic [NUM_C*OSW-1:0]  w_score;
  logic [OUTWIDTH-1:0]   w_cls;
  logic signed [OSW-1:0] w_best;
  logic [NUM_C*OSW-1:0]  r_predo;
  logic [OUTWIDTH-1:0]   r_out;
  logic                  r_out_valid;

  // Hidden layer neurons on the raw feature vector.
  for (genvar h = 0; h < NUM_H; h++) begin : g_hid
    logic [NUM_A*WW-1:0] w_w1_row;
    for (genvar i = 0; i < NUM_A; i++) begin : g_w
      assign w_w1_row[i*WW +: WW] = W1[h][i];
    end
    mlp_neuron #(
      .N_IN(NUM_A), .IN_W(WIDTH_A), .W_W(WW), .ACC_W(ACC1W),
      .OUT_W(ACTW), .SHIFT(HSHIFT), .RELU_EN(1'b1)
    ) u_neuron (
      .i_x(io_bus.inp), .i_w(w_w1_row), .i_b(B1[h]),
      .o_y_c(w_act[h*ACTW +: ACTW])
    );
  end

  // Stage 1: hidden activations and valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_act <= '0;
      r_v1  <= 1'b0;
    end else begin
      r_v1 <= io_bus.in_valid;
      if (io_bus.in_valid) begin
        r_act <= w_act;
      end
    end
  end

  // Output layer neurons on the registered activations.
  for (genvar c = 0; c < NUM_C; c++) begin : g_out
    logic [NUM_H*WW-1:0] w_w2_row;
    for (genvar h = 0; h < NUM_H; h++) begin : g_w
      assign w_w2_row[h*WW +: WW] = W2[c][h];
    end
    mlp_neuron #(
      .N_IN(NUM_H), .IN_W(ACTW), .W_W(WW), .ACC_W(OSW),
      .OUT_W(OSW), .SHIFT(0), .RELU_EN(1'b0)
    ) u_neuron (
      .i_x(r_act), .i_w(w_w2_row), .i_b(B2[c]),
      .o_y_c(w_score[c*OSW +: OSW])
    );
  end

  // Argmax; strict greater-than keeps the lowest index on ties.
  always_comb begin
    w_cls  = OUTWIDTH'(0);
    w_best = signed'(w_score[0 +: OSW]);
    for (int c = 1; c < int'(NUM_C); c++) begin
      if (signed'(w_score[c*OSW +: OSW]) > w_best) begin
        w_best = signed'(w_score[c*OSW +: OSW]);
        w_cls  = OUTWIDTH'(c);
      end
    end
  end

  // Stage 2: scores and class load only for valid samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_predo     <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_v1;
      if (r_v1) begin
        r_predo <= w_score;
        r_out   <= w_cls;
      end
    end
  end

  assign io_bus.predo     = r_predo;
  assign io_bus.out       = r_out;
  assign io_bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_cardio_mlp_classifier.sv
// Directed bench for cardio_mlp_classifier: reset values, hand-computed
// score vectors, argmax tie, back-to-back samples with a gap, a mixed
// stream against a reference model, and asynchronous reset mid-stream.
module tb_cardio_mlp_classifier;
  import cardio_mlp_pkg::*;

  localparam int unsigned XW = NUM_A * WIDTH_A;
  localparam int unsigned PW = NUM_C * OSW;
  localparam int N = 24;

  logic clk = 1'b0;
  logic rst;

  cardio_mlp_classifier_if bus ();
  cardio_mlp_classifier dut (.clk(clk), .rst(rst), .io_bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [XW-1:0]       vec [N];
  logic                vld [N];
  logic [PW-1:0]       hold_s;
  logic [OUTWIDTH-1:0] hold_c;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_scores(input string tag, input logic [PW-1:0] exp);
    for (int c = 0; c < int'(NUM_C); c++) begin
      check($sformatf("%s_score%0d", tag, c), 64'(bus.predo[c*OSW +: OSW]),
            64'(exp[c*OSW +: OSW]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] pack3(input int s0, input int s1, input int s2);
    logic [PW-1:0] r;
    r[0*OSW +: OSW] = OSW'(s0);
    r[1*OSW +: OSW] = OSW'(s1);
    r[2*OSW +: OSW] = OSW'(s2);
    return r;
  endfunction

  // Reference: integer arithmetic, divide for the shift, modulo for the wrap.
  function automatic logic [PW-1:0] model_scores(input logic [XW-1:0] x);
    int acc;
    int sc;
    int act [NUM_H];
    logic [PW-1:0] r;
    for (int h = 0; h < int'(NUM_H); h++) begin
      acc = int'(B1[h]);
      for (int i = 0; i < int'(NUM_A); i++) begin
        acc += int'(W1[h][i]) * int'(x[i*WIDTH_A +: WIDTH_A]);
      end
      act[h] = (acc < 0) ? 0 : ((acc / 16) % 256);
    end
    for (int c = 0; c < int'(NUM_C); c++) begin
      sc = int'(B2[c]);
      for (int h = 0; h < int'(NUM_H); h++) sc += int'(W2[c][h]) * act[h];
      r[c*OSW +: OSW] = OSW'(sc);
    end
    return r;
  endfunction

  function automatic logic [OUTWIDTH-1:0] model_cls(input logic [PW-1:0] s);
    int best;
    int bi;
    bi   = 0;
    best = int'(signed'(s[0 +: OSW]));
    for (int c = 1; c < int'(NUM_C); c++) begin
      if (int'(signed'(s[c*OSW +: OSW])) > best) begin
        best = int'(signed'(s[c*OSW +: OSW]));
        bi   = c;
      end
    end
    return OUTWIDTH'(bi);
  endfunction

  initial begin
    rst = 1'b1;
    bus.inp = '0;
    bus.in_valid = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out", 64'(bus.out), 64'd0);
    check("rst_predo", 64'(bus.predo), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // All-zero features: acts {1,0,3,0,6} -> scores {35,-23,45}, class 2.
    bus.inp = '0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("zero_out_valid", 64'(bus.out_valid), 64'd1);
    check("zero_out", 64'(bus.out), 64'd2);
    check_scores("zero", pack3(35, -23, 45));
    tick();
    check("gap_out_valid", 64'(bus.out_valid), 64'd0);
    check("gap_out_hold", 64'(bus.out), 64'd2);
    check_scores("gap_hold", pack3(35, -23, 45));

    // Back-to-back: f0=15 -> class 0, all 15 -> class 1, f7=15 -> class 2.
    bus.inp = XW'(4'hF);
    bus.in_valid = 1'b1;
    tick();
    bus.inp = '1;
    tick();
    check("b2b0_out_valid", 64'(bus.out_valid), 64'd1);
    check("b2b0_out", 64'(bus.out), 64'd0);
    check_scores("b2b0", pack3(29, -18, 26));
    bus.inp = XW'(4'hF) << (7 * WIDTH_A);
    tick();
    check("b2b1_out_valid", 64'(bus.out_valid), 64'd1);
    check("b2b1_out", 64'(bus.out), 64'd1);
    check_scores("b2b1_max", pack3(44, 51, 21));
    bus.in_valid = 1'b0;
    tick();
    check("b2b2_out_valid", 64'(bus.out_valid), 64'd1);
    check("b2b2_out", 64'(bus.out), 64'd2);
    check_scores("b2b2", pack3(43, -25, 44));
    tick();
    check("b2b_gap_valid", 64'(bus.out_valid), 64'd0);
    check("b2b_gap_out", 64'(bus.out), 64'd2);

    // f0=10 gives score0 == score2 > score1; lowest index wins.
    bus.inp = XW'(4'hA);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("tie_out_valid", 64'(bus.out_valid), 64'd1);
    check("tie_out", 64'(bus.out), 64'd0);
    check_scores("tie", pack3(30, -19, 30));
    hold_s = pack3(30, -19, 30);
    hold_c = 2'd0;

    // Mixed stream: fixed rows then random rows with random valid gaps.
    vec[0] = {21{4'h3}};
    vec[1] = {21{4'hC}};
    vec[2] = {7{12'h0F5}};
    vec[3] = {7{12'h90A}};
    for (int j = 0; j < N; j++) begin
      if (j >= 4) begin
        for (int i = 0; i < int'(NUM_A); i++) vec[j][i*WIDTH_A +: WIDTH_A] = 4'($urandom_range(15));
        vld[j] = ($urandom_range(3) != 0);
      end else begin
        vld[j] = 1'b1;
      end
    end
    for (int j = 0; j <= N; j++) begin
      if (j < N) begin
        bus.inp = vec[j];
        bus.in_valid = vld[j];
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      if (j >= 1) begin
        check($sformatf("strm%0d_out_valid", j - 1), 64'(bus.out_valid), 64'(vld[j-1]));
        if (vld[j-1]) begin
          hold_s = model_scores(vec[j-1]);
          hold_c = model_cls(hold_s);
        end
        check($sformatf("strm%0d_out", j - 1), 64'(bus.out), 64'(hold_c));
        check($sformatf("strm%0d_predo", j - 1), 64'(bus.predo), 64'(hold_s));
      end
    end

    // Asynchronous reset mid-stream, observed before the next clock edge.
    bus.inp = '0;
    bus.in_valid = 1'b1;
    tick();
    tick();
    check("pre_rst_out", 64'(bus.out), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out", 64'(bus.out), 64'd0);
    check("async_rst_predo", 64'(bus.predo), 64'd0);
    check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
    bus.in_valid = 1'b0;
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("post_rst_out", 64'(bus.out), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
